decode_rename_buffer: RTL and testbench

//   Parametrised in-order uOP queue between the decode stage(s) and rename.

---
 rtl/decode_rename_buffer.sv | 104 ++++++++++
 tb/tb_decode_rename_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/decode_rename_buffer.sv
// In-order uOP queue between decode and rename: compacts holey decode lanes into a
// circular buffer and presents up to OUT_W oldest entries per cycle.
module decode_rename_buffer #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2,
  parameter int DEPTH = 8,
  parameter int UOP_W = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         pause,
  input  logic [IN_W-1:0]              in_valid,
  input  logic [IN_W*UOP_W-1:0]        in_uop,
  output logic                         pause_req,
  output logic [OUT_W-1:0]             out_valid,
  output logic [OUT_W*UOP_W-1:0]       out_uop,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] IN_C    = CW'(IN_W);
  localparam logic [CW-1:0] OUT_C   = CW'(OUT_W);

  logic [UOP_W-1:0] storage [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic [CW-1:0] lane_off [IN_W];
  logic [PW-1:0] wr_idx   [IN_W];
  logic [CW-1:0] n_in, n_out, n_in_eff, n_out_eff;

  // Space check uses the registered, pre-pop occupancy so no input-to-stall path exists.
  assign pause_req = (DEPTH_C - count_reg) < IN_C;
  assign count     = count_reg;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_W; i++) begin
      lane_off[i] = n_in;
      if (in_valid[i]) n_in = n_in + CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_wr
      assign wr_idx[gi] = tail_reg + PW'(lane_off[gi]);
    end
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_rd
      logic [PW-1:0] rd_idx;
      assign rd_idx        = head_reg + PW'(gi);
      assign out_valid[gi] = count_reg > CW'(gi);
      assign out_uop[gi*UOP_W +: UOP_W] = out_valid[gi] ? storage[rd_idx] : '0;
    end
  endgenerate

  always_comb begin
    n_out      = (count_reg < OUT_C) ? count_reg : OUT_C;
    n_in_eff   = pause_req ? '0 : n_in;
    n_out_eff  = pause ? '0 : n_out;
    head_next  = head_reg + PW'(n_out_eff);
    tail_next  = tail_reg + PW'(n_in_eff);
    count_next = count_reg + n_in_eff - n_out_eff;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && !pause_req) begin
      for (int i = 0; i < IN_W; i++) begin
        if (in_valid[i]) storage[wr_idx[i]] <= in_uop[i*UOP_W +: UOP_W];
      end
    end
  end

`ifndef SYNTHESIS
  logic [OUT_W-1:0] valid_plus1;
  assign valid_plus1 = out_valid + OUT_W'(1);

  always @(posedge clk) begin
    if (!rst) begin
      assert (count_reg <= DEPTH_C) else $error("occupancy exceeds depth");
      assert ((out_valid & valid_plus1) == '0) else $error("out_valid not thermometer");
      assert (tail_reg == head_reg + PW'(count_reg)) else $error("tail/head/count inconsistent");
    end
  end
`endif

endmodule

// File: tb/tb_decode_rename_buffer.sv
// Directed self-checking bench for decode_rename_buffer in the default 4-in/2-out/8-deep config.
module tb_decode_rename_buffer;

  logic         clk = 1'b0;
  logic         rst, flush, pause;
  logic [3:0]   in_valid;
  logic [511:0] in_uop;
  logic         pause_req;
  logic [1:0]   out_valid;
  logic [255:0] out_uop;
  logic [3:0]   count;

  int tests = 0;
  int fails = 0;

  decode_rename_buffer #(.IN_W(4), .OUT_W(2), .DEPTH(8), .UOP_W(128)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .in_valid(in_valid), .in_uop(in_uop), .pause_req(pause_req),
    .out_valid(out_valid), .out_uop(out_uop), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [127:0] l0, input logic [127:0] l1,
                       input logic [127:0] l2, input logic [127:0] l3);
    in_valid = v;
    in_uop   = {l3, l2, l1, l0};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One line per checked cycle: valid, both lanes, count, stall request.
  task automatic expect_out(input string tag, input logic [1:0] v, input logic [127:0] u0,
                            input logic [127:0] u1, input logic [3:0] c, input logic pr);
    check({tag, ".valid"}, 128'(out_valid), 128'(v));
    check({tag, ".lane0"}, out_uop[127:0], u0);
    check({tag, ".lane1"}, out_uop[255:128], u1);
    check({tag, ".count"}, 128'(count), 128'(c));
    check({tag, ".pause_req"}, 128'(pause_req), 128'(pr));
    $display("[TB] %s valid=%b lane0=%0h lane1=%0h count=%0d pause_req=%b",
             tag, out_valid, out_uop[127:0], out_uop[255:128], count, pause_req);
  endtask

  localparam logic [127:0] A = 128'hA1, B = 128'hB2, C = 128'hC3, D = 128'hD4;
  localparam logic [127:0] E = 128'hE5, F = 128'hF6, G = 128'h17, H = 128'h28;
  localparam logic [127:0] P = 128'h31, Q = 128'h42, R = 128'h53, S = 128'h64;
  localparam logic [127:0] W = 128'h75, X = 128'h86, Y = 128'h97, Z = 128'hA8;
  localparam logic [127:0] T = 128'hB9, JUNK = 128'hDEAD;

  initial begin
    rst = 1'b1; flush = 1'b0; pause = 1'b0;
    drive(4'b0000, '0, '0, '0, '0);
    tick(); tick();
    expect_out("reset", 2'b00, '0, '0, 4'd0, 1'b0);
    rst = 1'b0;

    // Full-width push, drained two per cycle
    drive(4'b1111, A, B, C, D);
    tick();
    drive(4'b0000, JUNK, JUNK, JUNK, JUNK);
    expect_out("t1.c1", 2'b11, A, B, 4'd4, 1'b0);
    tick();
    expect_out("t1.c2", 2'b11, C, D, 4'd2, 1'b0);
    tick();
    expect_out("t1.c3", 2'b00, '0, '0, 4'd0, 1'b0);

    // Holes on lanes 0 and 2 are squeezed out
    drive(4'b1010, JUNK, B, JUNK, D);
    tick();
    drive(4'b0000, '0, '0, '0, '0);
    expect_out("t2.c1", 2'b11, B, D, 4'd2, 1'b0);
    tick();
    expect_out("t2.c2", 2'b00, '0, '0, 4'd0, 1'b0);

    // Head/tail now at 6: E..H occupy entries 6,7,0,1
    drive(4'b1111, E, F, G, H);
    tick();
    drive(4'b0000, '0, '0, '0, '0);
    expect_out("t4.c1", 2'b11, E, F, 4'd4, 1'b0);
    tick();
    expect_out("t4.c2", 2'b11, G, H, 4'd2, 1'b0);
    tick();
    expect_out("t4.c3", 2'b00, '0, '0, 4'd0, 1'b0);

    // Rename stalled: fill to full, then a further push is refused
    pause = 1'b1;
    drive(4'b1111, W, X, Y, Z);
    tick();
    expect_out("t3.c1", 2'b11, W, X, 4'd4, 1'b0);
    drive(4'b1111, P, Q, R, S);
    tick();
    expect_out("t3.c2", 2'b11, W, X, 4'd8, 1'b1);
    drive(4'b1111, JUNK, JUNK, JUNK, JUNK);
    tick();
    expect_out("t3.c3", 2'b11, W, X, 4'd8, 1'b1);
    pause = 1'b0;
    drive(4'b0000, '0, '0, '0, '0);
    tick();
    expect_out("t3.c4", 2'b11, Y, Z, 4'd6, 1'b1);
    tick();
    expect_out("t3.c5", 2'b11, P, Q, 4'd4, 1'b0);

    // Reach count 5, then flush with a same-cycle push
    pause = 1'b1;
    drive(4'b0001, T, '0, '0, '0);
    tick();
    expect_out("t5.c1", 2'b11, P, Q, 4'd5, 1'b1);
    pause = 1'b0;
    flush = 1'b1;
    drive(4'b1111, A, B, C, D);
    tick();
    flush = 1'b0;
    drive(4'b0000, '0, '0, '0, '0);
    expect_out("t5.c2", 2'b00, '0, '0, 4'd0, 1'b0);

    // Single entry popped while two more arrive
    pause = 1'b1;
    drive(4'b0001, X, '0, '0, '0);
    tick();
    expect_out("t6.c1", 2'b01, X, '0, 4'd1, 1'b0);
    pause = 1'b0;
    drive(4'b0011, Y, Z, '0, '0);
    tick();
    drive(4'b0000, '0, '0, '0, '0);
    expect_out("t6.c2", 2'b11, Y, Z, 4'd2, 1'b0);
    tick();
    expect_out("t6.c3", 2'b00, '0, '0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
